// File: rtl/emissor_barramento.sv
// Processor-side bus transaction issuer for an MSI snooping cache: decodes each CPU access
// into an optional victim write-back and bus message, sequences the handshakes, reports the new line state.
module emissor_barramento #(
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alternar,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             operacao,
  input  logic             acerto,
  input  logic [1:0]       estado,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [TAG_W-1:0] wb_tag,
  output logic             wb_req,
  output logic [TAG_W-1:0] wb_addr,
  input  logic             wb_ack,
  output logic             bus_req,
  output logic [1:0]       bus_msg,
  output logic [TAG_W-1:0] bus_tag,
  input  logic             bus_gnt,
  input  logic             bus_ack,
  output logic             done,
  output logic             err,
  output logic [1:0]       estado_final
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_SHD = 2'b01;
  localparam logic [1:0] ST_EXC = 2'b10;

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_RDM  = 2'b01;
  localparam logic [1:0] MSG_WRM  = 2'b10;
  localparam logic [1:0] MSG_INV  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_BREQ,
    S_BXFER,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       msg_q;
  logic [1:0]       fin_q;
  logic [TAG_W-1:0] tag_q;

  logic       accept;
  logic [1:0] dec_msg;
  logic [1:0] dec_fin;
  logic       dec_wb;

  assign req_ready = (state == S_IDLE) && !alternar;
  assign accept    = req_valid && req_ready;

  // Decode of the live request; only used on the accept cycle, results are then held.
  always_comb begin
    dec_msg = operacao ? MSG_WRM : MSG_RDM;
    dec_fin = operacao ? ST_EXC : ST_SHD;
    dec_wb  = 1'b0;
    case (estado)
      ST_SHD: begin
        if (acerto) begin
          dec_msg = operacao ? MSG_INV : MSG_NONE;
        end
      end
      ST_EXC: begin
        if (acerto) begin
          dec_msg = MSG_NONE;
          dec_fin = ST_EXC;
        end else begin
          dec_wb = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer; every output is set on the transition that enters the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      msg_q        <= MSG_NONE;
      fin_q        <= ST_INV;
      tag_q        <= '0;
      wb_req       <= 1'b0;
      wb_addr      <= '0;
      bus_req      <= 1'b0;
      bus_msg      <= MSG_NONE;
      bus_tag      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      estado_final <= ST_INV;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            msg_q <= dec_msg;
            fin_q <= dec_fin;
            tag_q <= tag_in;
            cnt   <= '0;
            if (dec_wb) begin
              state   <= S_WB;
              wb_req  <= 1'b1;
              wb_addr <= wb_tag;
            end else if (dec_msg != MSG_NONE) begin
              state   <= S_BREQ;
              bus_req <= 1'b1;
              bus_msg <= dec_msg;
              bus_tag <= tag_in;
            end else begin
              state        <= S_DONE;
              done         <= 1'b1;
              estado_final <= dec_fin;
            end
          end
        end
        S_WB: begin
          if (wb_ack) begin
            state   <= S_BREQ;
            cnt     <= '0;
            wb_req  <= 1'b0;
            wb_addr <= '0;
            bus_req <= 1'b1;
            bus_msg <= msg_q;
            bus_tag <= tag_q;
          end else if (cnt == CNT_LAST) begin
            state   <= S_ERR;
            wb_req  <= 1'b0;
            wb_addr <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BREQ: begin
          // A bus_ack coincident with the grant is ignored; it must recur in BXFER.
          if (bus_gnt) begin
            state <= S_BXFER;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_ERR;
            bus_req <= 1'b0;
            bus_msg <= MSG_NONE;
            bus_tag <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BXFER: begin
          if (bus_ack) begin
            state        <= S_DONE;
            bus_req      <= 1'b0;
            bus_msg      <= MSG_NONE;
            bus_tag      <= '0;
            done         <= 1'b1;
            estado_final <= fin_q;
          end else if (cnt == CNT_LAST) begin
            state   <= S_ERR;
            bus_req <= 1'b0;
            bus_msg <= MSG_NONE;
            bus_tag <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          state        <= S_IDLE;
          done         <= 1'b0;
          err          <= 1'b0;
          estado_final <= ST_INV;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
